adder_ring_counter: RTL and testbench

- Measurement stage directly downstream of wrapped_instrumented_adder.
- Consumes the adder's chain/ring output (`chain_out`) and enables the ring for a controlled window.
- Counts synchronized rising edges of the ring over a programmable gate of `wb_clk_i` cycles.
- Presents the result on logic-analyzer registers, giving a relative delay figure for the adder chain.

---
 rtl/adder_meas_pkg.sv | 15 +
 rtl/sync_rise_detect.sv | 28 ++
 rtl/adder_ring_counter.sv | 121 ++++++++++++
 tb/tb_adder_ring_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_meas_pkg.sv
// Shared types and default sizes for the adder ring-oscillator measurement stage.
package adder_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } state_t;

  localparam int CNT_W_DEF  = 24;
  localparam int GATE_W_DEF = 16;
  localparam int SETTLE_DEF = 8;

endpackage

// File: rtl/sync_rise_detect.sv
// Three-flop synchronizer for an asynchronous level, with a one-cycle pulse per rising edge.
module sync_rise_detect (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic d,
  output logic rise
);

  logic s1_p0;
  logic s2_p1;
  logic s3_p2;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
      s3_p2 <= 1'b0;
    end else begin
      s1_p0 <= d;
      s2_p1 <= s1_p0;
      s3_p2 <= s2_p1;
    end
  end

  // s1 may be metastable; the edge is taken from the settled s2/s3 pair.
  assign rise = s2_p1 & ~s3_p2;

endmodule

// File: rtl/adder_ring_counter.sv
// Gated edge counter for the instrumented adder ring: enable the ring, let it settle,
// then count synchronized rising edges for a programmable number of clocks.
module adder_ring_counter
  import adder_meas_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ring_in,
  output logic              ring_en,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

  state_t            state;
  logic              start_q;
  logic              armed;
  logic              start_rise;
  logic              ring_rise;
  logic [GATE_W-1:0] gate_q;
  logic [GATE_W-1:0] gate_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W:0]    count_inc;

  // Returns {saturated, next_count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, v};
    else    return {1'b0, v + CNT_W'(1)};
  endfunction

  sync_rise_detect u_ring_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .d        (ring_in),
    .rise     (ring_rise)
  );

  // armed blocks a launch from a start level that was already high when reset released.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      start_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) armed <= 1'b1;
    end
  end

  assign start_rise = start & ~start_q & armed;
  assign count_inc  = sat_inc(count);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      ring_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
      gate_q     <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            gate_q     <= gate_cycles;
            count      <= '0;
            overflow   <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
            ring_en    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(1)) begin
            if (gate_q != '0) begin
              gate_cnt <= gate_q;
              state    <= COUNT;
            end else begin
              state   <= DONE;
              ring_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        COUNT: begin
          if (ring_rise) begin
            count    <= count_inc[CNT_W-1:0];
            overflow <= overflow | count_inc[CNT_W];
          end
          if (gate_cnt == GATE_W'(1)) begin
            state   <= DONE;
            ring_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_ring_counter.sv
// Directed bench for adder_ring_counter: a 24-bit instance and a 4-bit instance share stimulus.
module tb_adder_ring_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_cycles = '0;
  logic        ring_in = 1'b0;

  logic        ring_en, busy, done, overflow;
  logic [23:0] count;
  logic        ring_en_s, busy_s, done_s, overflow_s;
  logic [3:0]  count_s;

  int n_tests = 0;
  int n_fail  = 0;

  int ring_half = 4;
  bit ring_on   = 1'b0;
  int ring_ph   = 0;
  bit en_err    = 1'b0;

  always #5 clk = ~clk;

  adder_ring_counter dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .start       (start),
    .gate_cycles (gate_cycles),
    .ring_in     (ring_in),
    .ring_en     (ring_en),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .count       (count)
  );

  adder_ring_counter #(.CNT_W(4)) dut_s (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .start       (start),
    .gate_cycles (gate_cycles),
    .ring_in     (ring_in),
    .ring_en     (ring_en_s),
    .busy        (busy_s),
    .done        (done_s),
    .overflow    (overflow_s),
    .count       (count_s)
  );

  // Ring model: toggles every ring_half clocks, changing mid-cycle so it is not edge-aligned.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!ring_on) begin
        ring_in = 1'b0;
        ring_ph = 0;
      end else begin
        ring_ph++;
        if (ring_ph >= ring_half) begin
          ring_in = ~ring_in;
          ring_ph = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Launch one measurement and return the number of clocks busy stayed high.
  // At busy cycle 'inject' a second start pulse is made and gate_cycles is changed to 5.
  task automatic run(input int gate, input int inject, output int len);
    @(negedge clk);
    gate_cycles = 16'(gate);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 0;
    while (busy && len < 2000) begin
      len++;
      if (ring_en !== busy) en_err = 1'b1;
      if (len == inject) begin
        start = 1'b1;
        gate_cycles = 16'd5;
      end
      if (len == inject + 2) start = 1'b0;
      @(negedge clk);
    end
  endtask

  int  len;
  logic seen;

  initial begin
    // Reset and quiet idle
    repeat (3) @(negedge clk);
    check("rst_flags", {28'd0, ring_en, busy, done, overflow}, 32'd0);
    check("rst_count", count, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen = seen | ring_en | busy | done | overflow | (count != 0);
    end
    check("idle_quiet", seen, 1'b0);

    // gate=80, ring period 8 -> about 10 edges
    ring_half = 4;
    ring_on = 1'b1;
    run(80, -10, len);
    check("g80_busy_len", len, 88);
    check("g80_done", done, 1'b1);
    check("g80_count_9to11", (count >= 9 && count <= 11), 1'b1);
    check("g80_ovf", overflow, 1'b0);
    check("g80_ring_en_off", ring_en, 1'b0);
    check("g80_en_tracks_busy", en_err, 1'b0);
    repeat (5) @(negedge clk);
    check("g80_count_held", (count >= 9 && count <= 11), 1'b1);

    // gate=0 -> settle only, nothing counted even with the ring toggling
    run(0, -10, len);
    check("g0_busy_len", len, 8);
    check("g0_done", done, 1'b1);
    check("g0_count", count, 32'd0);

    // gate=200, ring period 4 -> 4-bit instance saturates
    ring_half = 2;
    run(200, -10, len);
    check("sat_busy_len", len, 208);
    check("sat_done", done_s, 1'b1);
    check("sat_count", count_s, 32'd15);
    check("sat_ovf", overflow_s, 1'b1);
    check("wide_count_49to51", (count >= 49 && count <= 51), 1'b1);
    check("wide_ovf", overflow, 1'b0);

    // Second start with the ring held low clears count and overflow
    ring_on = 1'b0;
    run(10, -10, len);
    check("clr_busy_len", len, 18);
    check("clr_count", count_s, 32'd0);
    check("clr_ovf", overflow_s, 1'b0);

    // Start pulse and gate change mid-measurement are ignored
    ring_half = 4;
    ring_on = 1'b1;
    run(50, 20, len);
    check("ign_busy_len", len, 58);
    check("ign_done", done, 1'b1);
    @(negedge clk);
    gate_cycles = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 0;
    while (busy && len < 2000) begin
      len++;
      @(negedge clk);
    end
    check("restart_g5_len", len, 13);

    // Asynchronous reset mid-COUNT
    en_err = 1'b0;
    @(negedge clk);
    gate_cycles = 16'd80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_counting", (count != 0), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {29'd0, ring_en, busy, done}, 32'd0);
    check("arst_count", count, 32'd0);
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | busy | ring_en | done;
    end
    check("held_start_no_launch", seen, 1'b0);
    start = 1'b0;
    @(negedge clk);
    run(0, -10, len);
    check("post_rst_launch_len", len, 8);
    check("post_rst_done", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
